// File: rtl/rram_pulse_sequencer_if.sv
// Wishbone slave bus between the management SoC and the RRAM pulse sequencer.
interface rram_pulse_sequencer_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/rram_pulse_sequencer.sv
// RRAM crossbar address/select sequencer programmed over Wishbone.
// Produces timed break-before-make row/column select pulses and can scan
// consecutive addresses; all crossbar-facing outputs come straight from flops.
module rram_pulse_sequencer #(
  parameter int          ROW_BITS  = 11,
  parameter int          COL_BITS  = 9,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  rram_pulse_sequencer_if.slave wb,
  output logic [ROW_BITS-1:0]   rl_addr,
  output logic [ROW_BITS-1:0]   rl_addrb,
  output logic [COL_BITS-1:0]   cl_addr,
  output logic [COL_BITS-1:0]   cl_addrb,
  output logic                  rl_sel,
  output logic                  cl_sel,
  output logic                  busy,
  output logic                  irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_NEXT
  } state_t;

  state_t state, state_next;

  logic                cfg_auto_inc;
  logic                cfg_row_en;
  logic                cfg_col_en;
  logic [ROW_BITS-1:0] cfg_row;
  logic [COL_BITS-1:0] cfg_col;
  logic [7:0]          cfg_setup;
  logic [7:0]          cfg_pulse;
  logic [7:0]          cfg_hold;
  logic [7:0]          cfg_count;
  logic                done_flag;
  logic                aborted_flag;
  logic [7:0]          timer;
  logic [7:0]          issued;

  logic                hit;
  logic                wr_ctrl;
  logic                wr_addr;
  logic                wr_timing;
  logic                idle;
  logic                start_req;
  logic                abort_req;
  logic [31:0]         rd_data;

  logic [7:0]          setup_eff;
  logic [7:0]          pulse_eff;
  logic [7:0]          count_eff;

  logic                timer_ld;
  logic [7:0]          timer_val;
  logic                load_addr;
  logic                pulse_end;
  logic                advance;
  logic                finish;

  logic [ROW_BITS-1:0] row_adv;
  logic [COL_BITS-1:0] col_adv;

  logic                unused_bits;

  assign hit       = wb.wbs_stb_i & wb.wbs_cyc_i & ~wb.wbs_ack_o &
                     (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_ctrl   = hit & wb.wbs_we_i & (wb.wbs_adr_i[3:2] == 2'd0);
  assign wr_addr   = hit & wb.wbs_we_i & (wb.wbs_adr_i[3:2] == 2'd1);
  assign wr_timing = hit & wb.wbs_we_i & (wb.wbs_adr_i[3:2] == 2'd2);
  assign idle      = (state == S_IDLE);
  assign start_req = wr_ctrl & wb.wbs_dat_i[0] & idle;
  assign abort_req = wr_ctrl & wb.wbs_dat_i[4] & ~idle;

  assign setup_eff = (cfg_setup == 8'd0) ? 8'd1 : cfg_setup;
  assign pulse_eff = (cfg_pulse == 8'd0) ? 8'd1 : cfg_pulse;
  assign count_eff = (cfg_count == 8'd0) ? 8'd1 : cfg_count;

  assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0], wb.wbs_dat_i};

  // Register read mux; the selected word is captured into wbs_dat_o on the hit edge
  always_comb begin
    rd_data = '0;
    case (wb.wbs_adr_i[3:2])
      2'd0: rd_data[3:1] = {cfg_col_en, cfg_row_en, cfg_auto_inc};
      2'd1: begin
        rd_data[ROW_BITS-1:0]  = cfg_row;
        rd_data[16 +: COL_BITS] = cfg_col;
      end
      2'd2: rd_data = {cfg_count, cfg_hold, cfg_pulse, cfg_setup};
      default: begin
        rd_data[0]              = busy;
        rd_data[1]              = done_flag;
        rd_data[2]              = aborted_flag;
        rd_data[16 +: ROW_BITS] = rl_addr;
      end
    endcase
  end

  // Next scan address: column first, carrying into the row, both wrapping naturally
  always_comb begin
    row_adv = rl_addr;
    col_adv = cl_addr;
    if (cfg_auto_inc) begin
      if (cl_addr == '1) begin
        col_adv = '0;
        row_adv = rl_addr + ROW_BITS'(1);
      end else begin
        col_adv = cl_addr + COL_BITS'(1);
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Phase sequencing: each timed phase loads the timer and leaves when it reaches zero
  always_comb begin
    state_next = state;
    timer_ld   = 1'b0;
    timer_val  = 8'd0;
    load_addr  = 1'b0;
    pulse_end  = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_req) state_next = S_LOAD;
      end
      S_LOAD: begin
        state_next = S_SETUP;
        load_addr  = 1'b1;
        timer_ld   = 1'b1;
        timer_val  = setup_eff - 8'd1;
      end
      S_SETUP: begin
        if (timer == 8'd0) begin
          state_next = S_PULSE;
          timer_ld   = 1'b1;
          timer_val  = pulse_eff - 8'd1;
        end
      end
      S_PULSE: begin
        if (timer == 8'd0) begin
          pulse_end = 1'b1;
          if (cfg_hold == 8'd0) begin
            state_next = S_NEXT;
          end else begin
            state_next = S_HOLD;
            timer_ld   = 1'b1;
            timer_val  = cfg_hold - 8'd1;
          end
        end
      end
      S_HOLD: begin
        if (timer == 8'd0) state_next = S_NEXT;
      end
      S_NEXT: begin
        if (issued < count_eff) begin
          state_next = S_SETUP;
          advance    = 1'b1;
          timer_ld   = 1'b1;
          timer_val  = setup_eff - 8'd1;
        end else begin
          state_next = S_IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (abort_req) begin
      state_next = S_IDLE;
      timer_ld   = 1'b0;
      load_addr  = 1'b0;
      pulse_end  = 1'b0;
      advance    = 1'b0;
      finish     = 1'b0;
    end
  end

  // Wishbone acknowledge, read capture and configuration registers (frozen while busy)
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      cfg_auto_inc <= 1'b0;
      cfg_row_en   <= 1'b0;
      cfg_col_en   <= 1'b0;
      cfg_row      <= '0;
      cfg_col      <= '0;
      cfg_setup    <= '0;
      cfg_pulse    <= '0;
      cfg_hold     <= '0;
      cfg_count    <= '0;
    end else begin
      wb.wbs_ack_o <= hit;
      if (hit && !wb.wbs_we_i) wb.wbs_dat_o <= rd_data;
      if (wr_ctrl) begin
        cfg_auto_inc <= wb.wbs_dat_i[1];
        cfg_row_en   <= wb.wbs_dat_i[2];
        cfg_col_en   <= wb.wbs_dat_i[3];
      end
      if (wr_addr && idle) begin
        cfg_row <= wb.wbs_dat_i[ROW_BITS-1:0];
        cfg_col <= wb.wbs_dat_i[16 +: COL_BITS];
      end
      if (wr_timing && idle) begin
        cfg_setup <= wb.wbs_dat_i[7:0];
        cfg_pulse <= wb.wbs_dat_i[15:8];
        cfg_hold  <= wb.wbs_dat_i[23:16];
        cfg_count <= wb.wbs_dat_i[31:24];
      end
    end
  end

  // Crossbar outputs, phase timer, pulse counter and sticky status flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rl_addr      <= '0;
      rl_addrb     <= '1;
      cl_addr      <= '0;
      cl_addrb     <= '1;
      rl_sel       <= 1'b0;
      cl_sel       <= 1'b0;
      busy         <= 1'b0;
      irq          <= 1'b0;
      timer        <= '0;
      issued       <= '0;
      done_flag    <= 1'b0;
      aborted_flag <= 1'b0;
    end else begin
      if (load_addr) begin
        rl_addr  <= cfg_row;
        rl_addrb <= ~cfg_row;
        cl_addr  <= cfg_col;
        cl_addrb <= ~cfg_col;
      end else if (advance) begin
        rl_addr  <= row_adv;
        rl_addrb <= ~row_adv;
        cl_addr  <= col_adv;
        cl_addrb <= ~col_adv;
      end
      if (timer_ld) begin
        timer <= timer_val;
      end else if (timer != 8'd0) begin
        timer <= timer - 8'd1;
      end
      if (load_addr) begin
        issued <= 8'd0;
      end else if (pulse_end) begin
        issued <= issued + 8'd1;
      end
      if (start_req) begin
        done_flag    <= 1'b0;
        aborted_flag <= 1'b0;
      end
      if (finish) done_flag <= 1'b1;
      if (abort_req) aborted_flag <= 1'b1;
      irq    <= finish;
      busy   <= (state_next != S_IDLE);
      rl_sel <= (state_next == S_PULSE) && cfg_row_en;
      cl_sel <= (state_next == S_PULSE) && cfg_col_en;
    end
  end

endmodule

// File: tb/tb_rram_pulse_sequencer.sv
// Testbench for rram_pulse_sequencer: per-cycle trace comparison against a
// phase-duration model, plus abort, busy-write, address decode and reset scenarios.
module tb_rram_pulse_sequencer;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_ADDR   = BASE + 32'h4;
  localparam logic [31:0] A_TIMING = BASE + 32'h8;
  localparam logic [31:0] A_STATUS = BASE + 32'hC;

  typedef struct packed {
    logic [10:0] row;
    logic [8:0]  col;
    logic [7:0]  setup;
    logic [7:0]  pulse;
    logic [7:0]  hold;
    logic [7:0]  count;
    logic        auto_inc;
    logic        row_en;
    logic        col_en;
  } cfg_t;

  typedef struct packed {
    logic        busy;
    logic        rs;
    logic        cs;
    logic [10:0] row;
    logic [10:0] rowb;
    logic [8:0]  col;
    logic [8:0]  colb;
    logic        irq;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] rl_addr, rl_addrb;
  logic [8:0]  cl_addr, cl_addrb;
  logic        rl_sel, cl_sel, busy, irq;

  int tests    = 0;
  int failures = 0;

  logic [10:0] m_row;
  logic [8:0]  m_col;
  logic        m_done;
  logic        m_aborted;
  logic [31:0] m_addr_word;
  logic [31:0] m_timing_word;
  obs_t        exp_q[$];

  rram_pulse_sequencer_if wb ();

  rram_pulse_sequencer #(
    .ROW_BITS (11),
    .COL_BITS (9),
    .BASE_ADDR(BASE)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb      (wb),
    .rl_addr (rl_addr),
    .rl_addrb(rl_addrb),
    .cl_addr (cl_addr),
    .cl_addrb(cl_addrb),
    .rl_sel  (rl_sel),
    .cl_sel  (cl_sel),
    .busy    (busy),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic cfg_t mk_cfg(input logic [10:0] row, input logic [8:0] col,
                                  input logic [7:0] setup, input logic [7:0] pulse,
                                  input logic [7:0] hold, input logic [7:0] count,
                                  input logic auto_inc, input logic row_en, input logic col_en);
    cfg_t c;
    c.row = row; c.col = col; c.setup = setup; c.pulse = pulse; c.hold = hold;
    c.count = count; c.auto_inc = auto_inc; c.row_en = row_en; c.col_en = col_en;
    return c;
  endfunction

  function automatic obs_t mk_obs(input logic b, input logic rs, input logic cs,
                                  input logic [10:0] row, input logic [8:0] col, input logic ir);
    obs_t o;
    o.busy = b; o.rs = rs; o.cs = cs; o.row = row; o.rowb = ~row;
    o.col = col; o.colb = ~col; o.irq = ir;
    return o;
  endfunction

  function automatic logic [31:0] addr_word(input logic [10:0] row, input logic [8:0] col);
    return {7'd0, col, 5'd0, row};
  endfunction

  function automatic logic [31:0] timing_word(input cfg_t c);
    return {c.count, c.hold, c.pulse, c.setup};
  endfunction

  // Reference model: phase durations laid out cycle by cycle starting at the LOAD cycle
  task automatic build_trace(input cfg_t c);
    int s_eff, p_eff, n, base_idx, idx;
    logic [10:0] r;
    logic [8:0]  cc;
    s_eff    = (c.setup == 8'd0) ? 1 : int'(c.setup);
    p_eff    = (c.pulse == 8'd0) ? 1 : int'(c.pulse);
    n        = (c.count == 8'd0) ? 1 : int'(c.count);
    base_idx = int'(c.row) * 512 + int'(c.col);
    r  = c.row;
    cc = c.col;
    exp_q.delete();
    exp_q.push_back(mk_obs(1'b1, 1'b0, 1'b0, m_row, m_col, 1'b0));
    for (int k = 0; k < n; k++) begin
      idx = c.auto_inc ? (base_idx + k) % (1 << 20) : base_idx;
      r   = 11'(idx / 512);
      cc  = 9'(idx % 512);
      for (int i = 0; i < s_eff; i++) exp_q.push_back(mk_obs(1'b1, 1'b0, 1'b0, r, cc, 1'b0));
      for (int i = 0; i < p_eff; i++) exp_q.push_back(mk_obs(1'b1, c.row_en, c.col_en, r, cc, 1'b0));
      for (int i = 0; i < int'(c.hold); i++) exp_q.push_back(mk_obs(1'b1, 1'b0, 1'b0, r, cc, 1'b0));
      exp_q.push_back(mk_obs(1'b1, 1'b0, 1'b0, r, cc, 1'b0));
    end
    exp_q.push_back(mk_obs(1'b0, 1'b0, 1'b0, r, cc, 1'b1));
    exp_q.push_back(mk_obs(1'b0, 1'b0, 1'b0, r, cc, 1'b0));
    m_row = r; m_col = cc; m_done = 1'b1; m_aborted = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    bit got_ack;
    got_ack = 0;
    @(negedge clk);
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b1;
    wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = adr; wb.wbs_dat_i = dat;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(posedge clk);
      #1;
      if (wb.wbs_ack_o === 1'b1) got_ack = 1;
    end
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
    tests++;
    if (!got_ack) begin
      failures++;
      $display("[TB] FAIL write_ack adr=%h: got no ack, required ack within 8 cycles", adr);
    end
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    bit got_ack;
    got_ack = 0;
    dat = 32'hx;
    @(negedge clk);
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = adr;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(posedge clk);
      #1;
      if (wb.wbs_ack_o === 1'b1) begin
        got_ack = 1;
        dat = wb.wbs_dat_o;
      end
    end
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0;
    tests++;
    if (!got_ack) begin
      failures++;
      $display("[TB] FAIL read_ack adr=%h: got no ack, required ack within 8 cycles", adr);
    end
  endtask

  task automatic program_and_start(input cfg_t c);
    wb_write(A_ADDR, addr_word(c.row, c.col));
    wb_write(A_TIMING, timing_word(c));
    m_addr_word   = addr_word(c.row, c.col);
    m_timing_word = timing_word(c);
    wb_write(A_CTRL, {28'd0, c.col_en, c.row_en, c.auto_inc, 1'b1});
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({rl_addr, cl_addr, rl_sel, cl_sel, busy, irq, wb.wbs_ack_o} !== 25'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got addr=%h/%h sel=%b%b busy=%b irq=%b ack=%b, required all 0",
               rl_addr, cl_addr, rl_sel, cl_sel, busy, irq, wb.wbs_ack_o);
    end
    tests++;
    if (rl_addrb !== 11'h7FF || cl_addrb !== 9'h1FF) begin
      failures++;
      $display("[TB] FAIL reset_complements: got %h/%h, required 7ff/1ff", rl_addrb, cl_addrb);
    end
    rst = 1'b0;
    m_row = '0; m_col = '0; m_done = 1'b0; m_aborted = 1'b0;
    m_addr_word = '0; m_timing_word = '0;
    for (int a = 0; a < 4; a++) begin
      wb_read(BASE + 32'(a * 4), rd);
      tests++;
      if (rd !== 32'd0) begin
        failures++;
        $display("[TB] FAIL reset_reg%0d: got %h, required 00000000", a, rd);
      end
    end
  endtask

  task automatic test_sequences();
    cfg_t        list[$];
    obs_t        got;
    logic [31:0] rd;
    int          bad;
    list.push_back(mk_cfg(11'd5,    9'd3,     8'd2, 8'd4, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1));
    list.push_back(mk_cfg(11'd7,    9'h1FE,   8'd1, 8'd2, 8'd0, 8'd3, 1'b1, 1'b1, 1'b1));
    list.push_back(mk_cfg(11'h7FF,  9'h1FF,   8'd0, 8'd1, 8'd2, 8'd2, 1'b1, 1'b0, 1'b1));
    list.push_back(mk_cfg(11'h012,  9'h034,   8'd1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0));
    list.push_back(mk_cfg(11'h03A,  9'h010,   8'd3, 8'd1, 8'd3, 8'd2, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 12; i++) begin
      list.push_back(mk_cfg(11'($urandom_range(0, 2047)),
                            ($urandom_range(0, 1) == 1) ? 9'(511 - $urandom_range(0, 3))
                                                        : 9'($urandom_range(0, 511)),
                            8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                            8'($urandom_range(0, 2)), 8'($urandom_range(0, 4)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1))));
    end
    for (int n = 0; n < list.size(); n++) begin
      build_trace(list[n]);
      program_and_start(list[n]);
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        got = mk_obs(busy, rl_sel, cl_sel, rl_addr, cl_addr, irq);
        got.rowb = rl_addrb;
        got.colb = cl_addrb;
        tests++;
        if (got !== exp_q[i]) begin
          failures++;
          bad++;
          if (bad <= 4)
            $display("[TB] FAIL seq%0d_cycle%0d: got %h, required %h", n, i, got, exp_q[i]);
        end
      end
      wb_read(A_STATUS, rd);
      tests++;
      if (rd !== {5'd0, m_row, 16'd2}) begin
        failures++;
        $display("[TB] FAIL seq%0d_status: got %h, required %h", n, rd, {5'd0, m_row, 16'd2});
      end
      wb_read(A_CTRL, rd);
      tests++;
      if (rd !== {28'd0, list[n].col_en, list[n].row_en, list[n].auto_inc, 1'b0}) begin
        failures++;
        $display("[TB] FAIL seq%0d_ctrl_readback: got %h, required %h", n, rd,
                 {28'd0, list[n].col_en, list[n].row_en, list[n].auto_inc, 1'b0});
      end
    end
  endtask

  task automatic test_abort();
    cfg_t        c;
    logic [31:0] rd;
    bit          seen;
    bit          bad;
    c = mk_cfg(11'h155, 9'h0AA, 8'd1, 8'd30, 8'd0, 8'd2, 1'b0, 1'b1, 1'b1);
    program_and_start(c);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rl_sel === 1'b1) seen = 1;
    end
    tests++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL abort_pulse_start: got rl_sel=0 for 20 cycles, required 1");
    end
    wb_write(A_CTRL, 32'h0000_001C);
    tests++;
    if ({rl_sel, cl_sel, busy, irq} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL abort_immediate: got sel=%b%b busy=%b irq=%b, required 0000",
               rl_sel, cl_sel, busy, irq);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (irq !== 1'b0 || busy !== 1'b0 || rl_addr !== c.row || cl_addr !== c.col) bad = 1;
    end
    tests++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL abort_quiet: got irq/busy/address activity, required idle at %h/%h",
               c.row, c.col);
    end
    m_row = c.row; m_col = c.col; m_done = 1'b0; m_aborted = 1'b1;
    wb_read(A_STATUS, rd);
    tests++;
    if (rd !== {5'd0, m_row, 16'd4}) begin
      failures++;
      $display("[TB] FAIL abort_status: got %h, required %h", rd, {5'd0, m_row, 16'd4});
    end
  endtask

  task automatic test_busy_write();
    cfg_t        c;
    logic [31:0] rd;
    bit          bad;
    bit          ended;
    c = mk_cfg(11'h123, 9'h045, 8'd3, 8'd3, 8'd2, 8'd3, 1'b0, 1'b1, 1'b1);
    program_and_start(c);
    wb_write(A_ADDR, addr_word(11'h0AB, 9'h01C));
    wb_write(A_TIMING, 32'h0101_0101);
    bad = 0;
    ended = 0;
    for (int i = 0; i < 100 && !ended; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) ended = 1;
      else if (rl_addr !== c.row || cl_addr !== c.col) bad = 1;
    end
    tests++;
    if (!ended) begin
      failures++;
      $display("[TB] FAIL busy_write_end: got busy=1 after 100 cycles, required 0");
    end
    tests++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL busy_write_addr: got address change in flight, required %h/%h",
               c.row, c.col);
    end
    m_row = c.row; m_col = c.col; m_done = 1'b1; m_aborted = 1'b0;
    wb_read(A_ADDR, rd);
    tests++;
    if (rd !== m_addr_word) begin
      failures++;
      $display("[TB] FAIL busy_write_addr_reg: got %h, required %h", rd, m_addr_word);
    end
    wb_read(A_TIMING, rd);
    tests++;
    if (rd !== m_timing_word) begin
      failures++;
      $display("[TB] FAIL busy_write_timing_reg: got %h, required %h", rd, m_timing_word);
    end
    wb_read(A_STATUS, rd);
    tests++;
    if (rd !== {5'd0, m_row, 16'd2}) begin
      failures++;
      $display("[TB] FAIL busy_write_status: got %h, required %h", rd, {5'd0, m_row, 16'd2});
    end
  endtask

  task automatic test_bad_addr();
    logic [31:0] adrs[2];
    logic [31:0] rd;
    int          acks;
    adrs[0] = BASE + 32'h14;
    adrs[1] = 32'h4000_0004;
    for (int k = 0; k < 2; k++) begin
      acks = 0;
      @(negedge clk);
      wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = (k == 0);
      wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = adrs[k]; wb.wbs_dat_i = 32'h0155_0222;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk);
        #1;
        if (wb.wbs_ack_o !== 1'b0) acks++;
      end
      wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
      tests++;
      if (acks != 0) begin
        failures++;
        $display("[TB] FAIL bad_addr_ack adr=%h: got %0d ack cycles, required 0", adrs[k], acks);
      end
    end
    wb_read(A_ADDR, rd);
    tests++;
    if (rd !== m_addr_word) begin
      failures++;
      $display("[TB] FAIL bad_addr_no_write: got %h, required %h", rd, m_addr_word);
    end
  endtask

  task automatic test_reset_mid();
    cfg_t        c;
    logic [31:0] rd;
    bit          seen;
    c = mk_cfg(11'h2C3, 9'h187, 8'd2, 8'd25, 8'd1, 8'd2, 1'b1, 1'b1, 1'b1);
    program_and_start(c);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (cl_sel === 1'b1) seen = 1;
    end
    tests++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL reset_mid_pulse_start: got cl_sel=0 for 20 cycles, required 1");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({rl_addr, cl_addr, rl_sel, cl_sel, busy, irq} !== 24'd0 ||
        rl_addrb !== 11'h7FF || cl_addrb !== 9'h1FF) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: got addr=%h/%h addrb=%h/%h sel=%b%b busy=%b, required 0/0 7ff/1ff 00 0",
               rl_addr, cl_addr, rl_addrb, cl_addrb, rl_sel, cl_sel, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    m_row = '0; m_col = '0; m_done = 1'b0; m_aborted = 1'b0;
    wb_read(A_STATUS, rd);
    tests++;
    if (rd !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_status: got %h, required 00000000", rd);
    end
    wb_read(A_TIMING, rd);
    tests++;
    if (rd !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_timing: got %h, required 00000000", rd);
    end
  endtask

  // Scenario sequence
  initial begin
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'd0;
    wb.wbs_dat_i = 32'd0;
    test_reset();
    test_sequences();
    test_abort();
    test_busy_write();
    test_bad_addr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
